// File: rtl/dut_core.sv
// dut_core: single-bit debounce / glitch filter.
// The output follows the input only after the input has held a new value for
// STABLE_CYCLES consecutive rising edges. Shorter excursions are dropped and
// the count restarts from zero whenever the sample matches the output again.
// Optional two-flop input synchronizer: define DUT_CORE_SYNC_EN.
module dut_core #(
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_W         = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic out
);

  // Counter value at which the next differing sample commits the transition.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Reject configurations whose threshold does not fit the counter.
  generate
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << CNT_W)) begin : g_bad_param
      $error("dut_core: STABLE_CYCLES must be in 1..2**CNT_W");
    end
  endgenerate

  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;

`ifdef DUT_CORE_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Two-stage synchronizer chain; the filter sees the second stage.
  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
  end

  assign s = sync2_q;
`else
  // Input is already synchronous to clk and feeds the filter directly.
  assign s = in;
`endif

  // Next-state logic for the filter: hold, count, or commit the new value.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    out_d = out_q;
    cnt_d = cnt_q;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register updates from pre-edge values.
    if (!resetn) begin
      out_q   <= RESET_VAL;
      cnt_q   <= '0;
`ifdef DUT_CORE_SYNC_EN
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
`endif
    end else begin
      out_q   <= out_d;
      cnt_q   <= cnt_d;
`ifdef DUT_CORE_SYNC_EN
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
`endif
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_dut_core.sv
// tb_dut_core: directed self-checking bench for dut_core.
// Main instance uses defaults; three extra instances cover STABLE_CYCLES=1,
// STABLE_CYCLES=16 and RESET_VAL=1. Expected latencies add two edges when
// DUT_CORE_SYNC_EN is defined.
module tb_dut_core;

`ifdef DUT_CORE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic resetn;
  logic din, in1, in16, inr;
  logic dout, out1, out16, outr;

  int n_checks = 0;
  int n_fail   = 0;

  dut_core dut (
    .clk    (clk),
    .resetn (resetn),
    .in     (din),
    .out    (dout)
  );

  dut_core #(.STABLE_CYCLES(1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .in     (in1),
    .out    (out1)
  );

  dut_core #(.STABLE_CYCLES(16), .CNT_W(4)) dut16 (
    .clk    (clk),
    .resetn (resetn),
    .in     (in16),
    .out    (out16)
  );

  dut_core #(.RESET_VAL(1'b1)) dutr (
    .clk    (clk),
    .resetn (resetn),
    .in     (inr),
    .out    (outr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    logic       hist [$];

    resetn = 1'b0;
    din    = 1'b1;
    in1    = 1'b0;
    in16   = 1'b0;
    inr    = 1'b1;

    // Reset held for two edges with in=1.
    step();
    check("rst_out_e1", dout, 0);
    check("rst_cnt_e1", dut.cnt_q, 0);
    check("rstval_out", outr, 1);
    step();
    check("rst_out_e2", dout, 0);

    // Release with a quiet input.
    resetn = 1'b1;
    din    = 1'b0;
    repeat (2 + LAT) step();
    check("idle_out", dout, 0);

    // Clean rise: three held edges at 0, fourth commits.
    din = 1'b1;
    for (int k = 1; k <= 3 + LAT; k++) begin
      step();
      check("rise_hold", dout, 0);
    end
    step();
    check("rise_set", dout, 1);
    check("rise_cnt", dut.cnt_q, 0);

    // Clean fall, symmetric.
    din = 1'b0;
    for (int k = 1; k <= 3 + LAT; k++) begin
      step();
      check("fall_hold", dout, 1);
    end
    step();
    check("fall_set", dout, 0);

    // Glitch of three samples is rejected.
    din = 1'b1;
    repeat (3) step();
    din = 1'b0;
    for (int k = 1; k <= 3 + LAT; k++) begin
      step();
      check("glitch3", dout, 0);
    end
    check("glitch3_cnt", dut.cnt_q, 0);

    // 1,1,1,0 then 1 held: count restarts, out rises on the 8th edge.
    din = 1'b1;
    repeat (3) step();
    check("g2_a", dout, 0);
    din = 1'b0;
    step();
    check("g2_b", dout, 0);
    din = 1'b1;
    for (int k = 5; k <= 7 + LAT; k++) begin
      step();
      check("g2_hold", dout, 0);
    end
    step();
    check("g2_set", dout, 1);

    // Return to 0.
    din = 1'b0;
    repeat (4 + LAT) step();
    check("g2_back", dout, 0);

    // Reset mid-count aborts the pending rise.
    din = 1'b1;
    repeat (3) step();
    check("mid_cnt", dut.cnt_q, 3 - LAT);
    resetn = 1'b0;
    step();
    check("mid_rst_out", dout, 0);
    check("mid_rst_cnt", dut.cnt_q, 0);
    resetn = 1'b1;
    for (int k = 1; k <= 3 + LAT; k++) begin
      step();
      check("mid_hold", dout, 0);
    end
    step();
    check("mid_set", dout, 1);

    // Single-cycle pulse low is invisible on out.
    din = 1'b0;
    step();
    din = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("pulse", dout, 1);
    end

    // STABLE_CYCLES=1: out is the sample delayed by one register.
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      in1 = pat[i];
      hist.push_back(pat[i]);
      step();
      check("sc1", out1, (i >= LAT) ? hist[i - LAT] : 1'b0);
    end

    // STABLE_CYCLES=16: counter reaches 15 without wrapping.
    in16 = 1'b1;
    for (int k = 1; k <= 15 + LAT; k++) begin
      step();
      check("sc16_hold", out16, 0);
    end
    check("sc16_cnt15", dut16.cnt_q, 15);
    step();
    check("sc16_set", out16, 1);
    check("sc16_cnt0", dut16.cnt_q, 0);

    check("rstval_end", outr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
